// File: rtl/ahb_neuron_mac.sv
// Neuron MAC: AHB-Lite slave that accumulates signed 8x8 products, then shifts and saturates to 8 bits.
// Latency: the result is ready two cycles after the last DATA data phase. done_o pulses on the first DONE cycle.
// Backpressure: none; HREADYOUT is tied high, so every transfer completes in a single data phase.
module ahb_neuron_mac #(
  parameter int ACC_W = 24
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic [7:0]  result_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

  state_t                  state_q, state_d;
  logic                    dphase_vld, wr_q;
  logic [7:0]              addr_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [15:0]      prod_q;
  logic                    prod_vld;
  logic [7:0]              rem_q;
  logic [3:0]              shift_q;
  logic                    err_q;
  logic                    done_q;

  logic                    wr_dphase, start, data_wr, data_accept, enter_done;
  logic signed [15:0]      mul;
  logic signed [ACC_W-1:0] shifted;
  logic [7:0]              sat_dat;
  logic                    ovf;
  logic                    unused_ok;

  assign unused_ok = ^{HSIZE, HADDR[31:8], HWDATA[31:16], HTRANS[0]};

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 2'b00;

  assign wr_dphase   = dphase_vld & wr_q;
  assign start       = wr_dphase & (addr_q == 8'h00) & HWDATA[0];
  assign data_wr     = wr_dphase & (addr_q == 8'h04);
  assign data_accept = data_wr & (state_q == ACCUM);
  assign mul         = $signed(HWDATA[15:8]) * $signed(HWDATA[7:0]);

  // Capture the address phase so the following data phase knows what to do.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase_vld <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 8'h00;
    end else begin
      dphase_vld <= HSEL & HREADY & HTRANS[1];
      wr_q       <= HWRITE;
      addr_q     <= HADDR[7:0];
    end
  end

  // Job sequencing. A START overrides whatever the current state would do.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      ACCUM:   if (data_accept && rem_q == 8'd1) state_d = DRAIN;
      DRAIN:   if (prod_vld) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (start) state_d = (HWDATA[15:8] == 8'd0) ? DONE : ACCUM;
  end

  // The done pulse marks entry into DONE. A zero-length START issued in DONE re-enters it.
  assign enter_done = (state_d == DONE) && ((state_q != DONE) || start);

  // State register and done-pulse register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= enter_done;
    end
  end

  // Datapath. A captured product is added one edge later. START throws away any product still in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acc_q    <= '0;
      prod_q   <= '0;
      prod_vld <= 1'b0;
      rem_q    <= 8'd0;
      err_q    <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      prod_q   <= '0;
      prod_vld <= 1'b0;
      rem_q    <= HWDATA[15:8];
      err_q    <= 1'b0;
    end else begin
      if (prod_vld) acc_q <= acc_q + {{(ACC_W-16){prod_q[15]}}, prod_q};
      prod_vld <= data_accept;
      if (data_accept) begin
        prod_q <= mul;
        rem_q  <= rem_q - 8'd1;
      end
      if (data_wr && state_q != ACCUM) err_q <= 1'b1;
    end
  end

  // The SHIFT register is independent of job state. It is applied combinationally to the accumulator.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) shift_q <= 4'd0;
    else if (wr_dphase && addr_q == 8'h08) shift_q <= HWDATA[3:0];
  end

  // Arithmetic shift followed by saturation to a signed byte.
  always_comb begin
    shifted = acc_q >>> shift_q;
    sat_dat = shifted[7:0];
    if (shifted > SAT_MAX)      sat_dat = 8'h7F;
    else if (shifted < SAT_MIN) sat_dat = 8'h80;
  end

  assign ovf      = (state_q == DONE) && (shifted != {{(ACC_W-8){sat_dat[7]}}, sat_dat});
  assign result_o = sat_dat;
  assign done_o   = done_q;

  // Read mux. It is driven only in a read data phase and has no side effects.
  always_comb begin
    HRDATA = 32'h0;
    if (dphase_vld && !wr_q) begin
      case (addr_q)
        8'h08:   HRDATA = {28'h0, shift_q};
        8'h0C:   HRDATA = {16'h0, rem_q, 4'h0, err_q, ovf,
                           state_q == DONE, (state_q == ACCUM) || (state_q == DRAIN)};
        8'h10:   HRDATA = {24'h0, result_o};
        default: HRDATA = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_neuron_mac.sv
// Directed bench for ahb_neuron_mac. The stimulus pushes the expected read data and done events into queues.
// Latency: a monitor compares each read data phase and each done_o pulse against the queue heads.
// Backpressure: none; the bus model runs one non-pipelined transfer every two cycles.
module tb_ahb_neuron_mac;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0, HREADY = 1'b1, HWRITE = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HADDR = 32'h0, HWDATA = 32'h0;
  logic        HREADYOUT, done_o;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [7:0]  result_o;

  ahb_neuron_mac #(.ACC_W(24)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .result_o(result_o), .done_o(done_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int         cyc;
    logic [7:0] res;
  } done_exp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        rd_dp;
  done_exp_t   done_q[$];
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Cycle counter and read data phase tracker, both updated on the clock edge.
  always @(posedge HCLK) cyc <= cyc + 1;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rd_dp <= 1'b0;
    else          rd_dp <= HSEL && HREADY && HTRANS[1] && !HWRITE;
  end

  // Monitor: compare on the falling edge, away from the sampling edge.
  always @(negedge HCLK) begin
    if (rd_dp) begin
      if (rd_exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", HRDATA);
      end else begin
        check(rd_name_q.pop_front(), HRDATA, rd_exp_q.pop_front());
      end
    end
    if (done_o === 1'b1) begin
      if (done_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
      end else begin
        done_exp_t e;
        e = done_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_result", {24'h0, result_o}, {24'h0, e.res});
      end
    end
  end

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d, output int dcyc);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    dcyc = cyc;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    int dc;
    ahb_write(a, d, dc);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic start(input logic [7:0] n);
    wr(8'h00, {16'h0, n, 8'h01});
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] b);
    wr(8'h04, {16'h0, a, b});
  endtask

  // The last pair of a job. done_o is due two cycles after its data phase.
  task automatic last_pair(input logic [7:0] a, input logic [7:0] b, input logic [7:0] res);
    int dc;
    ahb_write(8'h04, {16'h0, a, b}, dc);
    done_q.push_back('{cyc: dc + 2, res: res});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, {24'h0, result_o}, 32'h0);
    check({tag, "_done"}, {31'h0, done_o}, 32'h0);
    check({tag, "_hrdata"}, HRDATA, 32'h0);
    check({tag, "_hreadyout"}, {31'h0, HREADYOUT}, 32'h1);
    check({tag, "_hresp"}, {30'h0, HRESP}, 32'h0);
  endtask

  initial begin
    int dc;
    #12;
    check_reset_outputs("por");
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Reset state as seen on the bus.
    rd(8'h0C, 32'h0, "reset_status");
    rd(8'h08, 32'h0, "reset_shift");
    rd(8'h10, 32'h0, "reset_result");

    // DATA write in IDLE sets ERR and leaves the accumulator untouched. Unmapped offsets read 0.
    pair(8'd5, 8'd5);
    rd(8'h0C, 32'h0000_0008, "idle_data_err");
    rd(8'h10, 32'h0, "idle_data_result");
    wr(8'h14, 32'hFFFF_FFFF);
    rd(8'h14, 32'h0, "unmapped_read");

    // 2*3 - 4*5 + 10*1 = -4 gives 0xFC.
    wr(8'h08, 32'h0);
    start(8'd3);
    pair(8'd2, 8'd3);
    pair(8'hFC, 8'd5);
    last_pair(8'd10, 8'd1, 8'hFC);
    rd(8'h0C, 32'h0000_0002, "basic_status");
    rd(8'h10, 32'h0000_00FC, "basic_result");

    // 2*127*127 = 32258. Shifting by 4 gives 2016, which saturates to 127. Shifting by 8 gives 126.
    wr(8'h08, 32'h4);
    start(8'd2);
    pair(8'd127, 8'd127);
    last_pair(8'd127, 8'd127, 8'h7F);
    rd(8'h10, 32'h0000_007F, "sat_pos_result");
    rd(8'h0C, 32'h0000_0006, "sat_pos_status");
    wr(8'h08, 32'h8);
    rd(8'h08, 32'h8, "shift_readback");
    rd(8'h10, 32'h0000_007E, "shift8_result");
    rd(8'h0C, 32'h0000_0002, "shift8_status");

    // -128*127 = -16256 saturates to -128.
    wr(8'h08, 32'h0);
    start(8'd1);
    last_pair(8'h80, 8'd127, 8'h80);
    rd(8'h10, 32'h0000_0080, "sat_neg_result");
    rd(8'h0C, 32'h0000_0006, "sat_neg_status");

    // Abort a job in ACCUM, then run a new one. Only the new job produces a done_o pulse.
    start(8'd4);
    pair(8'd50, 8'd50);
    pair(8'd50, 8'd50);
    rd(8'h0C, 32'h0000_0201, "accum_status");
    start(8'd1);
    last_pair(8'd1, 8'd1, 8'h01);
    rd(8'h10, 32'h0000_0001, "abort_result");

    // N=0 goes straight to DONE with result 0. A later DATA write there sets ERR and changes nothing.
    ahb_write(8'h00, 32'h0000_0001, dc);
    done_q.push_back('{cyc: dc + 1, res: 8'h00});
    rd(8'h10, 32'h0, "n0_result");
    rd(8'h0C, 32'h0000_0002, "n0_status");
    pair(8'd9, 8'd9);
    rd(8'h0C, 32'h0000_000A, "done_data_err");
    rd(8'h10, 32'h0, "done_data_result");

    // Assert reset while in DRAIN. There must be no done_o pulse, and the next job must be correct.
    start(8'd2);
    pair(8'd3, 8'd3);
    pair(8'd4, 8'd4);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("drain_rst");
    @(posedge HCLK);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    rd(8'h0C, 32'h0, "post_rst_status");
    start(8'd1);
    last_pair(8'd3, 8'hFE, 8'hFA);
    rd(8'h10, 32'h0000_00FA, "post_rst_result");
    rd(8'h0C, 32'h0000_0002, "post_rst_status_done");

    repeat (5) @(posedge HCLK);
    #1;
    check("done_queue_drained", done_q.size(), 0);
    check("read_queue_drained", rd_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_neuron_mac.md
AHB_NEURON_MAC -- requirements
Module: ahb_neuron_mac

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator width in bits (signed).
REQ-002 SHALL have port HCLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have AHB-Lite slave inputs HSEL 1, HREADY 1, HTRANS 2, HSIZE 3, HWRITE 1, HADDR 32, HWDATA 32.
REQ-005 SHALL have AHB-Lite slave outputs HREADYOUT 1 (tied 1), HRESP 2 (tied 0), HRDATA 32.
REQ-006 SHALL have port result_o  output  8  saturated signed neuron pre-activation, the input to the downstream sigmoid stage.
REQ-007 SHALL have port done_o  output  1  one-cycle pulse when result_o becomes valid.

Function
REQ-008 SHALL register an address phase (HSEL & HREADY & HTRANS[1]) as HADDR[7:0] plus a write/read flag, and act on it in the following data phase.
REQ-009 SHALL decode offsets: 0x00 CTRL (W), 0x04 DATA (W), 0x08 SHIFT (R/W, bits[3:0]), 0x0C STATUS (R), 0x10 RESULT (R); other offsets read 0, writes ignored.
REQ-010 SHALL drive HRDATA combinationally in the data phase: STATUS = {16'b0, remaining[7:0], 4'b0, ERR, OVF, DONE, BUSY}; RESULT = {24'b0, result_o}.
REQ-011 SHALL use a four-state FSM: IDLE, ACCUM, DRAIN, DONE.
REQ-012 CTRL write with bit0=1, in any state, SHALL clear the accumulator, OVF, ERR and the product-valid flag, and load remaining = HWDATA[15:8].
REQ-013 On that CTRL write, N=0 SHALL go directly to DONE, with result 0 and done_o pulsed in the next cycle; N>0 SHALL go to ACCUM.
REQ-014 A DATA write in ACCUM SHALL capture prod = signed(HWDATA[15:8]) * signed(HWDATA[7:0]) and set product-valid at that edge, and decrement remaining.
REQ-015 The DATA write that brings remaining to 0 SHALL move the FSM to DRAIN.
REQ-016 Whenever product-valid is set, the accumulator SHALL add sign-extended prod on the next edge and clear product-valid, unless a new product is captured at the same edge.
REQ-017 DRAIN SHALL move to DONE on the edge that accumulates the last product, so DONE is visible two cycles after the last DATA data phase.
REQ-018 done_o SHALL pulse for exactly the first cycle in DONE.
REQ-019 result_o SHALL equal the accumulator arithmetically shifted right by SHIFT, then saturated to [-128, 127].
REQ-020 OVF SHALL be set in DONE when saturation changes the value.
REQ-021 result_o SHALL hold its value in DONE until the next START.
REQ-022 A DATA write in IDLE, DRAIN or DONE SHALL be ignored and SHALL set sticky ERR.
REQ-023 A START during ACCUM or DRAIN SHALL abort the job; any in-flight product SHALL be discarded, not accumulated.
REQ-024 BUSY SHALL be 1 in ACCUM and DRAIN; DONE bit SHALL be 1 in DONE only.
REQ-025 SHIFT SHALL be sampled combinationally, so a SHIFT write in DONE updates result_o on the next cycle.
REQ-026 Reads SHALL have no side effects.

Reset
REQ-027 Asserting HRESETn low, at any time including mid-job, SHALL immediately force: FSM IDLE, accumulator 0, prod 0, product-valid 0, remaining 0, SHIFT 0, OVF 0, ERR 0, registered address/flags 0.
REQ-028 During reset, outputs SHALL be result_o=0, done_o=0, HRDATA=0, HREADYOUT=1, HRESP=0.
REQ-029 After reset release, the first AHB transfer SHALL be accepted in the first clock cycle.

Verification
REQ-030 SHIFT=0; CTRL N=3; DATA pairs (2,3),(-4,5),(10,1) -> done_o 2 cycles after last write; RESULT 0xFC; STATUS DONE=1, OVF=0.
REQ-031 SHIFT=4; N=2; pairs (127,127)x2, accumulator 32258 -> RESULT 0x7F, OVF=1; then write SHIFT=8 -> RESULT 0x7E, OVF=0.
REQ-032 SHIFT=0; N=1; pair (-128,127) -> RESULT 0x80, OVF=1.
REQ-033 N=4 with 2 pairs written, then START N=1 with pair (1,1) -> RESULT 0x01, exactly one done_o pulse.
REQ-034 N=0 -> DONE next cycle, RESULT 0; DATA write in IDLE -> ERR=1, accumulator unchanged.
REQ-035 Reset asserted in DRAIN -> all STATUS bits 0, no done_o pulse, next job correct.
